ltx_pattern_gen: RTL and testbench

- Parametrised fabric-side test-pattern generator for the LVDS DAC transmit bus.
- Produces one SER-bit serializer word per data lane, plus a strobe word and a forwarded-clock word, every app_clk frame.
- Supports static, square-wave and ramp DAC-code patterns, per-lane masking, and shadowed configuration applied on a load pulse.
- Sits between control logic and the high-speed SelectIO TX core; its outputs drive data_from_fabric_* directly.

---
 rtl/ltx_pattern_gen.sv | 197 +++++++++++++++++++
 tb/tb_ltx_pattern_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltx_pattern_gen.sv
// Fabric-side test-pattern generator for the LVDS DAC transmit bus.
// Emits one SER-bit word per DAC lane, a strobe word and a forwarded-clock word each frame.
module ltx_pattern_gen #(
  parameter int LANES = 12,
  parameter int SER   = 8,
  parameter int CNT_W = 16
) (
  input  logic                  app_clk,
  input  logic                  rst_n_in,
  input  logic                  en,
  input  logic                  cfg_load,
  input  logic [1:0]            mode,
  input  logic [LANES-1:0]      code_lo,
  input  logic [LANES-1:0]      code_hi,
  input  logic [LANES-1:0]      step,
  input  logic [CNT_W-1:0]      half_period,
  input  logic [LANES-1:0]      lane_mask,
  input  logic [SER-1:0]        strobe_pat,
  output logic [LANES*SER-1:0]  lane_data,
  output logic [SER-1:0]        strobe_data,
  output logic [SER-1:0]        clk_fwd_data,
  output logic                  active,
  output logic                  level_probe,
  output logic [CNT_W-1:0]      frame_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [SER-1:0] fwd_word();
    logic [SER-1:0] w;
    for (int i = 0; i < SER; i++) w[i] = ((i % 2) == 0);
    return w;
  endfunction

  localparam logic [SER-1:0] CLK_FWD = fwd_word();

  // Builds one frame: sample i goes to bit SER-1-i of each lane word (first on the wire).
  function automatic logic [LANES*SER-1:0] build_frame(
    input logic [1:0]       m,
    input logic [LANES-1:0] lo,
    input logic [LANES-1:0] hi,
    input logic [LANES-1:0] st,
    input logic [LANES-1:0] acc,
    input logic             lvl,
    input logic [LANES-1:0] mask
  );
    logic [LANES*SER-1:0] w;
    logic [LANES-1:0]     s;
    w = '0;
    for (int i = 0; i < SER; i++) begin
      case (m)
        2'd1:    s = lvl ? hi : lo;
        2'd2:    s = acc + LANES'(i) * st;
        default: s = lo;
      endcase
      for (int l = 0; l < LANES; l++) w[l*SER + SER-1-i] = s[l] & mask[l];
    end
    return w;
  endfunction

  state_t               state_q, state_d;
  logic [1:0]           mode_sh_q, mode_sh_d;
  logic [LANES-1:0]     code_lo_sh_q, code_lo_sh_d;
  logic [LANES-1:0]     code_hi_sh_q, code_hi_sh_d;
  logic [LANES-1:0]     step_sh_q, step_sh_d;
  logic [CNT_W-1:0]     half_period_sh_q, half_period_sh_d;
  logic [LANES-1:0]     lane_mask_sh_q, lane_mask_sh_d;
  logic [SER-1:0]       strobe_sh_q, strobe_sh_d;
  logic [CNT_W-1:0]     sq_cnt_q, sq_cnt_d;
  logic                 level_q, level_d;
  logic [LANES-1:0]     acc_q, acc_d;
  logic [LANES*SER-1:0] lane_data_q, lane_data_d;
  logic [SER-1:0]       strobe_q, strobe_d;
  logic                 active_q, active_d;
  logic                 level_probe_q, level_probe_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                 phase_rst;
  logic [CNT_W-1:0]     hp_m1;

  assign hp_m1 = (half_period_sh_q == '0) ? '0 : half_period_sh_q - CNT_W'(1);

  always_comb begin
    state_d          = state_q;
    mode_sh_d        = mode_sh_q;
    code_lo_sh_d     = code_lo_sh_q;
    code_hi_sh_d     = code_hi_sh_q;
    step_sh_d        = step_sh_q;
    half_period_sh_d = half_period_sh_q;
    lane_mask_sh_d   = lane_mask_sh_q;
    strobe_sh_d      = strobe_sh_q;
    sq_cnt_d         = sq_cnt_q;
    level_d          = level_q;
    acc_d            = acc_q;
    lane_data_d      = '0;
    strobe_d         = '0;
    level_probe_d    = 1'b0;
    frame_cnt_d      = frame_cnt_q;
    phase_rst        = 1'b0;

    if (cfg_load) begin
      mode_sh_d        = mode;
      code_lo_sh_d     = code_lo;
      code_hi_sh_d     = code_hi;
      step_sh_d        = step;
      half_period_sh_d = half_period;
      lane_mask_sh_d   = lane_mask;
      strobe_sh_d      = strobe_pat;
    end

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d     = RUN;
          frame_cnt_d = '0;
          phase_rst   = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          lane_data_d   = build_frame(mode_sh_q, code_lo_sh_q, code_hi_sh_q, step_sh_q,
                                      acc_q, level_q, lane_mask_sh_q);
          strobe_d      = strobe_sh_q;
          level_probe_d = level_q;
          frame_cnt_d   = frame_cnt_q + CNT_W'(1);
          if (mode_sh_q == 2'd1) begin
            if (sq_cnt_q == hp_m1) begin
              sq_cnt_d = '0;
              level_d  = ~level_q;
            end else begin
              sq_cnt_d = sq_cnt_q + CNT_W'(1);
            end
          end
          if (mode_sh_q == 2'd2) acc_d = acc_q + LANES'(SER) * step_sh_q;
          phase_rst = cfg_load;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load at this edge must seed the ramp from the incoming code, not the stale shadow.
    if (phase_rst) begin
      sq_cnt_d = '0;
      level_d  = 1'b0;
      acc_d    = cfg_load ? code_lo : code_lo_sh_q;
    end

    active_d = (state_d == RUN);
  end

  always_ff @(posedge app_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q          <= IDLE;
      mode_sh_q        <= '0;
      code_lo_sh_q     <= '0;
      code_hi_sh_q     <= '0;
      step_sh_q        <= '0;
      half_period_sh_q <= '0;
      lane_mask_sh_q   <= '0;
      strobe_sh_q      <= '0;
      sq_cnt_q         <= '0;
      level_q          <= 1'b0;
      acc_q            <= '0;
      lane_data_q      <= '0;
      strobe_q         <= '0;
      active_q         <= 1'b0;
      level_probe_q    <= 1'b0;
      frame_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      mode_sh_q        <= mode_sh_d;
      code_lo_sh_q     <= code_lo_sh_d;
      code_hi_sh_q     <= code_hi_sh_d;
      step_sh_q        <= step_sh_d;
      half_period_sh_q <= half_period_sh_d;
      lane_mask_sh_q   <= lane_mask_sh_d;
      strobe_sh_q      <= strobe_sh_d;
      sq_cnt_q         <= sq_cnt_d;
      level_q          <= level_d;
      acc_q            <= acc_d;
      lane_data_q      <= lane_data_d;
      strobe_q         <= strobe_d;
      active_q         <= active_d;
      level_probe_q    <= level_probe_d;
      frame_cnt_q      <= frame_cnt_d;
    end
  end

  assign lane_data    = lane_data_q;
  assign strobe_data  = strobe_q;
  assign clk_fwd_data = CLK_FWD;
  assign active       = active_q;
  assign level_probe  = level_probe_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_ltx_pattern_gen.sv
// Randomised bench for ltx_pattern_gen against a closed-form frame model.
module tb_ltx_pattern_gen;
  localparam int LANES = 12;
  localparam int SER   = 8;
  localparam int CNT_W = 16;

  logic                 app_clk = 1'b0;
  logic                 rst_n_in, en, cfg_load;
  logic [1:0]           mode;
  logic [LANES-1:0]     code_lo, code_hi, step, lane_mask;
  logic [CNT_W-1:0]     half_period;
  logic [SER-1:0]       strobe_pat;
  logic [LANES*SER-1:0] lane_data;
  logic [SER-1:0]       strobe_data, clk_fwd_data;
  logic                 active, level_probe;
  logic [CNT_W-1:0]     frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 app_clk = ~app_clk;

  ltx_pattern_gen #(.LANES(LANES), .SER(SER), .CNT_W(CNT_W)) dut (
    .app_clk(app_clk), .rst_n_in(rst_n_in), .en(en), .cfg_load(cfg_load),
    .mode(mode), .code_lo(code_lo), .code_hi(code_hi), .step(step),
    .half_period(half_period), .lane_mask(lane_mask), .strobe_pat(strobe_pat),
    .lane_data(lane_data), .strobe_data(strobe_data), .clk_fwd_data(clk_fwd_data),
    .active(active), .level_probe(level_probe), .frame_cnt(frame_cnt)
  );

  // Frame n (1 = first frame after the phase restart), computed directly from the pattern rules.
  function automatic int model_level(input int hp, input int n);
    int h;
    h = (hp == 0) ? 1 : hp;
    return ((n - 1) / h) % 2;
  endfunction

  function automatic logic [LANES*SER-1:0] model_frame(input int m, input logic [LANES-1:0] lo,
      input logic [LANES-1:0] hi, input logic [LANES-1:0] st, input int hp,
      input logic [LANES-1:0] mk, input int n);
    logic [LANES*SER-1:0] w;
    logic [LANES-1:0]     s;
    w = '0;
    for (int i = 0; i < SER; i++) begin
      if (m == 1)      s = (model_level(hp, n) == 1) ? hi : lo;
      else if (m == 2) s = LANES'(int'(lo) + ((n - 1) * SER + i) * int'(st));
      else             s = lo;
      for (int l = 0; l < LANES; l++) w[l*SER + SER-1-i] = s[l] & mk[l];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge app_clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [LANES-1:0] lo, input logic [LANES-1:0] hi,
      input logic [LANES-1:0] st, input logic [CNT_W-1:0] hp, input logic [LANES-1:0] mk,
      input logic [SER-1:0] sp);
    mode = m; code_lo = lo; code_hi = hi; step = st;
    half_period = hp; lane_mask = mk; strobe_pat = sp; cfg_load = 1'b1;
  endtask

  // Garbage on the cfg pins after a load: the shadow copy must be what governs frames.
  task automatic scramble();
    cfg_load = 1'b0;
    mode = 2'($urandom); code_lo = 12'($urandom); code_hi = 12'($urandom);
    step = 12'($urandom); half_period = 16'($urandom); lane_mask = 12'($urandom);
    strobe_pat = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; en = 1'b0; cfg_load = 1'b0;
    mode = '0; code_lo = '0; code_hi = '0; step = '0; half_period = '0; lane_mask = '0; strobe_pat = '0;
    #12;
    n_tests++; if (lane_data !== '0) begin n_fail++; $display("FAIL reset_lane got=%h exp=0", lane_data); end
    n_tests++; if (strobe_data !== '0) begin n_fail++; $display("FAIL reset_strobe got=%h exp=0", strobe_data); end
    n_tests++; if (clk_fwd_data !== 8'h55) begin n_fail++; $display("FAIL reset_clkfwd got=%h exp=55", clk_fwd_data); end
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", active); end
    n_tests++; if (frame_cnt !== '0) begin n_fail++; $display("FAIL reset_fcnt got=%0d exp=0", frame_cnt); end
    tick();
    rst_n_in = 1'b1;
    tick(); tick();
    n_tests++; if (lane_data !== '0) begin n_fail++; $display("FAIL idle_lane got=%h exp=0", lane_data); end
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL idle_active got=%b exp=0", active); end
    n_tests++; if (clk_fwd_data !== 8'h55) begin n_fail++; $display("FAIL idle_clkfwd got=%h exp=55", clk_fwd_data); end
  endtask

  task automatic test_static();
    set_cfg(2'd0, 12'hA5A, 12'h000, 12'h000, 16'd0, 12'hFFF, 8'h3C);
    tick(); scramble(); en = 1'b1;
    tick();
    n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL static_active got=%b exp=1", active); end
    n_tests++; if (lane_data !== '0) begin n_fail++; $display("FAIL static_latency got=%h exp=0", lane_data); end
    tick();
    n_tests++; if (lane_data[0 +: 8] !== 8'h00) begin n_fail++; $display("FAIL static_l0 got=%h exp=00", lane_data[0 +: 8]); end
    n_tests++; if (lane_data[8 +: 8] !== 8'hFF) begin n_fail++; $display("FAIL static_l1 got=%h exp=ff", lane_data[8 +: 8]); end
    n_tests++; if (lane_data[24 +: 8] !== 8'hFF) begin n_fail++; $display("FAIL static_l3 got=%h exp=ff", lane_data[24 +: 8]); end
    n_tests++; if (lane_data[88 +: 8] !== 8'hFF) begin n_fail++; $display("FAIL static_l11 got=%h exp=ff", lane_data[88 +: 8]); end
    n_tests++; if (strobe_data !== 8'h3C) begin n_fail++; $display("FAIL static_strobe got=%h exp=3c", strobe_data); end
    n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL static_fcnt got=%0d exp=1", frame_cnt); end
    tick();
    n_tests++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL static_fcnt2 got=%0d exp=2", frame_cnt); end
    en = 1'b0;
    tick();
    n_tests++; if (lane_data !== '0 || strobe_data !== '0 || active !== 1'b0) begin
      n_fail++; $display("FAIL en_off got lane=%h strobe=%h active=%b exp all 0", lane_data, strobe_data, active); end
  endtask

  task automatic test_square();
    logic [LANES*SER-1:0] exp_w;
    set_cfg(2'd1, 12'h000, 12'hFFF, 12'h000, 16'd8, 12'h7FF, 8'hA1);
    tick(); scramble(); en = 1'b1;
    tick();
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp_w = model_frame(1, 12'h000, 12'hFFF, 12'h000, 8, 12'h7FF, n);
      n_tests++; if (lane_data !== exp_w) begin n_fail++; $display("FAIL square_f%0d got=%h exp=%h", n, lane_data, exp_w); end
      n_tests++; if (level_probe !== 1'(model_level(8, n))) begin
        n_fail++; $display("FAIL square_lvl_f%0d got=%b exp=%0d", n, level_probe, model_level(8, n)); end
      n_tests++; if (lane_data[88 +: 8] !== 8'h00) begin n_fail++; $display("FAIL square_l11_f%0d got=%h exp=00", n, lane_data[88 +: 8]); end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_ramp();
    set_cfg(2'd2, 12'h000, 12'h000, 12'h001, 16'd0, 12'hFFF, 8'hFF);
    tick(); scramble(); en = 1'b1;
    tick(); tick();
    n_tests++; if (lane_data[0 +: 8] !== 8'h55) begin n_fail++; $display("FAIL ramp_l0 got=%h exp=55", lane_data[0 +: 8]); end
    n_tests++; if (lane_data[8 +: 8] !== 8'h33) begin n_fail++; $display("FAIL ramp_l1 got=%h exp=33", lane_data[8 +: 8]); end
    n_tests++; if (lane_data[16 +: 8] !== 8'h0F) begin n_fail++; $display("FAIL ramp_l2 got=%h exp=0f", lane_data[16 +: 8]); end
    n_tests++; if (lane_data[24 +: 8] !== 8'h00) begin n_fail++; $display("FAIL ramp_l3 got=%h exp=00", lane_data[24 +: 8]); end
    tick();
    n_tests++; if (lane_data[24 +: 8] !== 8'hFF) begin n_fail++; $display("FAIL ramp_f2_l3 got=%h exp=ff", lane_data[24 +: 8]); end
    en = 1'b0;
    tick();
    set_cfg(2'd2, 12'hFFE, 12'h000, 12'h001, 16'd0, 12'hFFF, 8'h0F);
    tick(); scramble(); en = 1'b1;
    tick(); tick();
    n_tests++; if (lane_data[88 +: 8] !== 8'hC0) begin n_fail++; $display("FAIL wrap_l11 got=%h exp=c0", lane_data[88 +: 8]); end
    n_tests++; if (lane_data !== model_frame(2, 12'hFFE, 0, 1, 0, 12'hFFF, 1)) begin
      n_fail++; $display("FAIL wrap_f1 got=%h exp=%h", lane_data, model_frame(2, 12'hFFE, 0, 1, 0, 12'hFFF, 1)); end
    tick();
    n_tests++; if (lane_data[8 +: 8] !== 8'hCC) begin n_fail++; $display("FAIL wrap_f2_l1 got=%h exp=cc", lane_data[8 +: 8]); end
    n_tests++; if (lane_data[88 +: 8] !== 8'h00) begin n_fail++; $display("FAIL wrap_f2_l11 got=%h exp=00", lane_data[88 +: 8]); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_cfg_midrun();
    logic [LANES*SER-1:0] exp_w;
    logic [LANES-1:0]     lo2, lo3, hi3, mk3;
    lo2 = 12'($urandom); lo3 = 12'($urandom); hi3 = 12'($urandom); mk3 = 12'($urandom);
    set_cfg(2'd1, 12'h123, 12'hEDC, 12'h000, 16'd2, 12'hFFF, 8'h99);
    tick(); scramble(); en = 1'b1;
    tick();
    for (int n = 1; n <= 5; n++) tick();
    set_cfg(2'd0, lo2, 12'h000, 12'h000, 16'd0, 12'hFFF, 8'h42);
    tick();
    exp_w = model_frame(1, 12'h123, 12'hEDC, 0, 2, 12'hFFF, 6);
    n_tests++; if (lane_data !== exp_w) begin n_fail++; $display("FAIL midrun_old got=%h exp=%h", lane_data, exp_w); end
    scramble();
    tick();
    exp_w = model_frame(0, lo2, 0, 0, 0, 12'hFFF, 1);
    n_tests++; if (lane_data !== exp_w) begin n_fail++; $display("FAIL midrun_static got=%h exp=%h", lane_data, exp_w); end
    n_tests++; if (strobe_data !== 8'h42) begin n_fail++; $display("FAIL midrun_strobe got=%h exp=42", strobe_data); end
    n_tests++; if (frame_cnt !== 16'd7) begin n_fail++; $display("FAIL midrun_fcnt got=%0d exp=7", frame_cnt); end
    set_cfg(2'd1, lo3, hi3, 12'h000, 16'd3, mk3, 8'h18);
    tick(); scramble();
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_w = model_frame(1, lo3, hi3, 0, 3, mk3, n);
      n_tests++; if (lane_data !== exp_w) begin n_fail++; $display("FAIL restart_f%0d got=%h exp=%h", n, lane_data, exp_w); end
      n_tests++; if (level_probe !== 1'(model_level(3, n))) begin
        n_fail++; $display("FAIL restart_lvl_f%0d got=%b exp=%0d", n, level_probe, model_level(3, n)); end
    end
    n_tests++; if (frame_cnt !== 16'd15) begin n_fail++; $display("FAIL restart_fcnt got=%0d exp=15", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [LANES-1:0] lo_b;
    lo_b = 12'($urandom);
    en = 1'b0;
    set_cfg(2'd0, lo_b, 12'h000, 12'h000, 16'd0, 12'hFFF, 8'h77);
    tick();
    n_tests++; if (lane_data !== '0 || active !== 1'b0) begin
      n_fail++; $display("FAIL b2b_off got lane=%h active=%b exp 0", lane_data, active); end
    scramble(); en = 1'b1;
    tick();
    n_tests++; if (lane_data !== '0) begin n_fail++; $display("FAIL b2b_latency got=%h exp=0", lane_data); end
    tick();
    n_tests++; if (lane_data !== model_frame(0, lo_b, 0, 0, 0, 12'hFFF, 1)) begin
      n_fail++; $display("FAIL b2b_new got=%h exp=%h", lane_data, model_frame(0, lo_b, 0, 0, 0, 12'hFFF, 1)); end
    n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL b2b_fcnt got=%0d exp=1", frame_cnt); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    set_cfg(2'd2, 12'($urandom), 12'h000, 12'($urandom), 16'd0, 12'hFFF, 8'hE7);
    tick(); scramble(); en = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    #2 rst_n_in = 1'b0;
    #1;
    n_tests++; if (lane_data !== '0 || strobe_data !== '0) begin
      n_fail++; $display("FAIL arst_data got lane=%h strobe=%h exp 0", lane_data, strobe_data); end
    n_tests++; if (frame_cnt !== '0 || active !== 1'b0) begin
      n_fail++; $display("FAIL arst_ctrl got fcnt=%0d active=%b exp 0", frame_cnt, active); end
    n_tests++; if (clk_fwd_data !== 8'h55) begin n_fail++; $display("FAIL arst_clkfwd got=%h exp=55", clk_fwd_data); end
    tick();
    rst_n_in = 1'b1;
    tick();
    n_tests++; if (lane_data !== '0 || active !== 1'b1) begin
      n_fail++; $display("FAIL arst_rel got lane=%h active=%b exp lane=0 active=1", lane_data, active); end
    tick();
    n_tests++; if (lane_data !== '0 || strobe_data !== '0 || frame_cnt !== 16'd1) begin
      n_fail++; $display("FAIL arst_shadow got lane=%h strobe=%h fcnt=%0d exp 0/0/1", lane_data, strobe_data, frame_cnt); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [LANES*SER-1:0] exp_w;
    logic [1:0] m; logic [LANES-1:0] lo, hi, st, mk; logic [CNT_W-1:0] hp; logic [SER-1:0] sp;
    for (int it = 0; it < 8; it++) begin
      m = 2'($urandom); lo = 12'($urandom); hi = 12'($urandom); st = 12'($urandom);
      mk = 12'($urandom); hp = 16'($urandom_range(0, 3)); sp = 8'($urandom);
      set_cfg(m, lo, hi, st, hp, mk, sp);
      tick(); scramble(); en = 1'b1;
      tick();
      for (int n = 1; n <= 10; n++) begin
        tick();
        exp_w = model_frame(int'(m), lo, hi, st, int'(hp), mk, n);
        n_tests++; if (lane_data !== exp_w || strobe_data !== sp || frame_cnt !== 16'(n)) begin
          n_fail++; $display("FAIL rand%0d_f%0d got lane=%h strobe=%h fcnt=%0d exp lane=%h strobe=%h fcnt=%0d",
                             it, n, lane_data, strobe_data, frame_cnt, exp_w, sp, n); end
        if (m == 2'd1) begin
          n_tests++; if (level_probe !== 1'(model_level(int'(hp), n))) begin
            n_fail++; $display("FAIL rand%0d_lvl_f%0d got=%b exp=%0d", it, n, level_probe, model_level(int'(hp), n)); end
        end
      end
      en = 1'b0;
      tick();
      n_tests++; if (lane_data !== '0 || active !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_off got lane=%h active=%b exp 0", it, lane_data, active); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_static();
    test_square();
    test_ramp();
    test_cfg_midrun();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
